// File: rtl/aes_key_schedule_seq_pkg.sv
// Shared types, round constants and the single-round expansion step of the AES-128 key schedule.
package aes_key_schedule_seq_pkg;

  localparam logic [3:0] AES_NR    = 4'd10;
  localparam int         AES_NKEYS = 11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_t;

  // Rounds outside 1..10 are never requested; they return 0.
  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] rc;
    case (r)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  // sub_w is SubWord(RotWord(w3)) of k, produced by the S-box instances.
  function automatic logic [127:0] next_key(input logic [127:0] k,
                                            input logic [31:0]  sub_w,
                                            input logic [7:0]   rc);
    logic [31:0] t, w0, w1, w2, w3;
    t  = sub_w ^ {rc, 24'h0};
    w0 = k[127:96] ^ t;
    w1 = k[95:64]  ^ w0;
    w2 = k[63:32]  ^ w1;
    w3 = k[31:0]   ^ w2;
    return {w0, w1, w2, w3};
  endfunction

endpackage

// File: rtl/aes_key_schedule_seq_sbox.sv
// AES forward S-box, purely combinational byte lookup.
module aes_key_schedule_seq_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] s_o
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign s_o = SBOX[a_i];

endmodule

// File: rtl/aes_key_schedule_seq.sv
// Forward AES-128 key schedule: streams round keys over valid/ready, one per cycle when unstalled.
// Optional 11-entry key store for the decryption path is enabled by defining KEY_SCHED_STORE_EN.
module aes_key_schedule_seq #(
  parameter int unsigned EMIT_ROUND0 = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key,
  output logic         busy,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_key,
  output logic [3:0]   out_round,
  output logic         done,
  input  logic [3:0]   rd_round,
  output logic [127:0] rd_key,
  output logic         keys_valid
);
  import aes_key_schedule_seq_pkg::*;

  state_t       state_q, state_d;
  logic [3:0]   round_q, round_d;
  logic [127:0] key_q, key_d;
  logic         done_q, done_d;

  logic         emit, accept, hs, last;
  logic [127:0] exp_src, exp_key;
  logic [31:0]  rot_w, sub_w;
  logic [3:0]   rc_idx;

  assign emit   = (state_q == ST_EMIT);
  assign accept = (state_q == ST_IDLE) && start;
  assign hs     = emit && out_ready;
  assign last   = (round_q == AES_NR);

  // In IDLE the S-boxes see the incoming key so round 1 can be preloaded when round 0 is skipped.
  assign exp_src = emit ? key_q : key;
  assign rot_w   = rot_word(exp_src[31:0]);
  assign rc_idx  = emit ? (round_q + 4'd1) : 4'd1;

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_key_schedule_seq_sbox u_sbox (
      .a_i (rot_w[8*i +: 8]),
      .s_o (sub_w[8*i +: 8])
    );
  end

  assign exp_key = next_key(exp_src, sub_w, rcon(rc_idx));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start)       state_d = ST_EMIT;
      ST_EMIT: if (hs && last)  state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = emit;
    out_valid = emit;
    out_key   = emit ? key_q : '0;
    out_round = emit ? round_q : '0;
    done      = done_q;
  end

  always_comb begin
    key_d   = key_q;
    round_d = round_q;
    if (accept) begin
      if (EMIT_ROUND0 != 0) begin
        key_d   = key;
        round_d = 4'd0;
      end else begin
        key_d   = exp_key;
        round_d = 4'd1;
      end
    end else if (hs && !last) begin
      key_d   = exp_key;
      round_d = round_q + 4'd1;
    end
    done_d = hs && last;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q   <= '0;
      round_q <= '0;
      done_q  <= 1'b0;
    end else begin
      key_q   <= key_d;
      round_q <= round_d;
      done_q  <= done_d;
    end
  end

`ifdef KEY_SCHED_STORE_EN
  logic [127:0] store_q [AES_NKEYS];
  logic         kv_q;

  // Without round 0 on the stream, the cipher key is captured into entry 0 at start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < AES_NKEYS; i++) store_q[i] <= '0;
      kv_q <= 1'b0;
    end else begin
      for (int i = 0; i < AES_NKEYS; i++) begin
        if (hs && (round_q == 4'(i)))
          store_q[i] <= key_q;
        else if (accept && (EMIT_ROUND0 == 0) && (i == 0))
          store_q[i] <= key;
      end
      if (accept)           kv_q <= 1'b0;
      else if (hs && last)  kv_q <= 1'b1;
    end
  end

  always_comb begin
    rd_key = '0;
    for (int i = 0; i < AES_NKEYS; i++) begin
      if (rd_round == 4'(i)) rd_key = store_q[i];
    end
  end

  assign keys_valid = kv_q;
`else
  logic unused_rd_round;
  assign unused_rd_round = ^rd_round;
  assign rd_key          = '0;
  assign keys_valid      = 1'b0;
`endif

endmodule

// File: tb/tb_aes_key_schedule_seq.sv
// Directed bench for aes_key_schedule_seq using the FIPS-197 appendix A.1 key.
module tb_aes_key_schedule_seq;

  logic         clk = 1'b0;
  logic         rst_n, start, start0, out_ready, out_ready0;
  logic [127:0] key;
  logic [3:0]   rd_round;

  logic         busy, out_valid, done, keys_valid;
  logic [127:0] out_key, rd_key;
  logic [3:0]   out_round;
  logic         busy0, out_valid0, done0, keys_valid0;
  logic [127:0] out_key0, rd_key0;
  logic [3:0]   out_round0;

  int total = 0;
  int bad   = 0;

  logic [127:0] rk [0:10];
  logic [127:0] alt_key;

  aes_key_schedule_seq #(.EMIT_ROUND0(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key(key), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .out_key(out_key),
    .out_round(out_round), .done(done), .rd_round(rd_round),
    .rd_key(rd_key), .keys_valid(keys_valid)
  );

  aes_key_schedule_seq #(.EMIT_ROUND0(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .key(key), .busy(busy0),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_key(out_key0),
    .out_round(out_round0), .done(done0), .rd_round(rd_round),
    .rd_key(rd_key0), .keys_valid(keys_valid0)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  int           idx, dones;
  logic         stalled;
  logic [127:0] pk;
  logic [3:0]   pr;

  initial begin
    rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    alt_key = 128'h000102030405060708090a0b0c0d0e0f;

    rst_n = 1'b0; start = 1'b0; start0 = 1'b0;
    out_ready = 1'b1; out_ready0 = 1'b1;
    key = rk[0]; rd_round = 4'd0;
    #12;
    check("rst_busy", busy, 0);
    check("rst_valid", out_valid, 0);
    check("rst_key", out_key, 0);
    check("rst_round", out_round, 0);
    check("rst_done", done, 0);
    check("rst_kv", keys_valid, 0);
    check("rst_rdkey", rd_key, 0);
    tick(); rst_n = 1'b1; tick();

    // Full run, consumer always ready.
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k <= 10; k++) begin
      check("t1_valid", out_valid, 1);
      check("t1_busy", busy, 1);
      check("t1_round", out_round, 128'(k));
      check("t1_key", out_key, rk[k]);
      check("t1_nodone", done, 0);
      tick();
    end
    check("t1_done", done, 1);
    check("t1_idle_busy", busy, 0);
    check("t1_idle_valid", out_valid, 0);
`ifdef KEY_SCHED_STORE_EN
    check("st_kv", keys_valid, 1);
    rd_round = 4'd0;  #1 check("st_rd0", rd_key, rk[0]);
    rd_round = 4'd10; #1 check("st_rd10", rd_key, rk[10]);
    rd_round = 4'd12; #1 check("st_rd12", rd_key, 0);
`else
    check("nost_kv", keys_valid, 0);
    rd_round = 4'd10; #1 check("nost_rd", rd_key, 0);
`endif
    tick();
    check("t1_done_pulse", done, 0);

    // Same key under random backpressure.
    start = 1'b1; tick(); start = 1'b0;
`ifdef KEY_SCHED_STORE_EN
    check("st_kv_clear", keys_valid, 0);
`endif
    idx = 0; dones = 0; stalled = 1'b0; pk = '0; pr = '0;
    for (int c = 0; c < 120; c++) begin
      if (done) dones++;
      if (stalled) begin
        check("t2_hold_key", out_key, pk);
        check("t2_hold_round", out_round, 128'(pr));
      end
      out_ready = (c % 3 != 1) && ($urandom_range(0, 1) == 1);
      if (out_valid && out_ready) begin
        check("t2_round", out_round, 128'(idx));
        check("t2_key", out_key, (idx <= 10) ? rk[idx] : '1);
        idx++;
      end
      stalled = out_valid && !out_ready;
      pk = out_key;
      pr = out_round;
      tick();
    end
    out_ready = 1'b1;
    check("t2_count", 128'(idx), 11);
    check("t2_dones", 128'(dones), 1);

    // start during busy with another key must be ignored.
    key = rk[0]; start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k <= 10; k++) begin
      check("t3_round", out_round, 128'(k));
      check("t3_key", out_key, rk[k]);
      if (k == 4) begin start = 1'b1; key = alt_key; end
      else start = 1'b0;
      tick();
    end
    check("t3_done", done, 1);

    // start coincident with done is accepted.
    key = rk[0]; start = 1'b1; tick(); start = 1'b0;
    check("t4_valid", out_valid, 1);
    check("t4_round0", out_round, 0);
    check("t4_key0", out_key, rk[0]);
    for (int k = 1; k <= 6; k++) begin
      tick();
      check("t4_round", out_round, 128'(k));
    end

    // Asynchronous abort at round 6.
    #2 rst_n = 1'b0;
    #1;
    check("t5_busy", busy, 0);
    check("t5_valid", out_valid, 0);
    check("t5_key", out_key, 0);
    check("t5_done", done, 0);
    check("t5_kv", keys_valid, 0);
    tick(); rst_n = 1'b1; tick();
    check("t5_nodone", done, 0);
    check("t5_idle", busy, 0);
    start = 1'b1; tick(); start = 1'b0;
    check("t5_r0_valid", out_valid, 1);
    check("t5_r0_round", out_round, 0);
    check("t5_r0_key", out_key, rk[0]);
    tick();
    check("t5_r1_key", out_key, rk[1]);
    for (int k = 2; k <= 10; k++) tick();
    check("t5_r10_key", out_key, rk[10]);
    tick();
    check("t5_done_end", done, 1);

    // Round 0 suppressed.
    key = rk[0]; start0 = 1'b1; tick(); start0 = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      check("t6_valid", out_valid0, 1);
      check("t6_round", out_round0, 128'(k));
      check("t6_key", out_key0, rk[k]);
      check("t6_nodone", done0, 0);
      tick();
    end
    check("t6_done", done0, 1);
    check("t6_busy", busy0, 0);
`ifndef KEY_SCHED_STORE_EN
    check("t6_rdkey", rd_key0, 0);
    check("t6_kv", keys_valid0, 0);
`else
    check("t6_kv", keys_valid0, 1);
    rd_round = 4'd1; #1 check("t6_rd1", rd_key0, rk[1]);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
